// File: rtl/grid_mem_pkg.sv
// Shared types and default dimensions for the grid memory.
// Exports: state_t (IDLE/CLEAR) and GM_* default parameter values.
package grid_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int GM_DATA_W = 1;
    localparam int GM_WIDTH  = 16;
    localparam int GM_HEIGHT = 16;
    localparam int GM_ADDR_W = 4;
    localparam int GM_ADDR_H = 4;

endpackage

// File: rtl/grid_clear_ctrl.sv
// Sweep counter for the bulk clear: walks every cell, y fastest, x outer.
// Ports: clk, rst (async high), i_start (restart from [0][0]),
//        o_x/o_y (cell being cleared), o_busy (sweep active),
//        o_done (last cell is being cleared this cycle).
module grid_clear_ctrl
    import grid_mem_pkg::*;
#(
    parameter int WIDTH  = GM_WIDTH,
    parameter int HEIGHT = GM_HEIGHT,
    parameter int ADDR_W = GM_ADDR_W,
    parameter int ADDR_H = GM_ADDR_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_x,
    output logic [ADDR_H-1:0] o_y,
    output logic              o_busy,
    output logic              o_done
);

    // Terminal values follow the real dimensions, not the address width.
    localparam logic [ADDR_W-1:0] LP_XMAX = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_H-1:0] LP_YMAX = ADDR_H'(HEIGHT - 1);

    logic [ADDR_W-1:0] r_x;
    logic [ADDR_H-1:0] r_y;
    logic              r_busy;
    logic              w_y_last;
    logic              w_last;

    assign w_y_last = (r_y == LP_YMAX);
    assign w_last   = w_y_last && (r_x == LP_XMAX);

    // Reset leaves the sweep armed at [0][0]; it runs from the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_busy <= 1'b1;
        end else if (i_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (w_last) begin
                r_x    <= '0;
                r_y    <= '0;
                r_busy <= 1'b0;
            end else if (w_y_last) begin
                r_y <= '0;
                r_x <= r_x + 1'b1;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_busy = r_busy;
    assign o_done = r_busy && w_last;

endmodule

// File: rtl/grid_memory.sv
// WIDTH x HEIGHT cell array with registered reads and a bulk-clear sweep.
// Ports: clk, rst (async high), wr/rd/clr requests, addr_x/addr_y,
//        data_in; data_out + rd_valid (latency 1), busy, err pulse.
module grid_memory
    import grid_mem_pkg::*;
#(
    parameter int DATA_W = GM_DATA_W,
    parameter int WIDTH  = GM_WIDTH,
    parameter int HEIGHT = GM_HEIGHT,
    parameter int ADDR_W = GM_ADDR_W,
    parameter int ADDR_H = GM_ADDR_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr_x,
    input  logic [ADDR_H-1:0] addr_y,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    // One extra bit so WIDTH/HEIGHT of 256 still compare correctly.
    localparam logic [ADDR_W:0] LP_XLIM = (ADDR_W + 1)'(WIDTH);
    localparam logic [ADDR_H:0] LP_YLIM = (ADDR_H + 1)'(HEIGHT);

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [WIDTH][HEIGHT];
    logic [DATA_W-1:0] r_data;
    logic              r_rd_valid;
    logic              r_err;

    logic [ADDR_W-1:0] w_sx;
    logic [ADDR_H-1:0] w_sy;
    logic              w_busy;
    logic              w_done;
    logic              w_idle;
    logic              w_start;
    logic              w_in_range;
    logic              w_accept;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_bad;

    grid_clear_ctrl #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W),
        .ADDR_H (ADDR_H)
    ) u_clear (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .o_x     (w_sx),
        .o_y     (w_sy),
        .o_busy  (w_busy),
        .o_done  (w_done)
    );

    assign w_idle     = (r_state == IDLE);
    assign w_start    = w_idle && clr;
    assign w_in_range = ({1'b0, addr_x} < LP_XLIM)
                     && ({1'b0, addr_y} < LP_YLIM);

    // clr wins over rd/wr in the same cycle; nothing is accepted in CLEAR.
    assign w_accept = w_idle && !clr;
    assign w_wr_ok  = w_accept && wr && w_in_range;
    assign w_rd_ok  = w_accept && rd && w_in_range;
    assign w_bad    = w_accept && (rd || wr) && !w_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (clr) begin
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (w_done) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Array has no reset; only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[w_sx][w_sy] <= '0;
        end else if (w_wr_ok) begin
            r_mem[addr_x][addr_y] <= data_in;
        end
    end

    // Reads sample the array before this edge's write: read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data     <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            r_err      <= w_bad;
            if (w_rd_ok) begin
                r_data <= r_mem[addr_x][addr_y];
            end
        end
    end

    assign data_out = r_data;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_grid_memory.sv
// Bench for grid_memory: a 16x16 and a 10x6 instance share one stimulus.
// An array model predicts every output each cycle; directed checks pin it.
module tb_grid_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] ax  = '0;
    logic [3:0] ay  = '0;
    logic [3:0] din = '0;

    logic [3:0] a_do;
    logic       a_rv;
    logic       a_busy;
    logic       a_err;
    logic [3:0] b_do;
    logic       b_rv;
    logic       b_busy;
    logic       b_err;

    int  total = 0;
    int  bad   = 0;
    bit  armed = 1'b0;

    grid_memory #(
        .DATA_W (4),
        .WIDTH  (16),
        .HEIGHT (16),
        .ADDR_W (4),
        .ADDR_H (4)
    ) u_a (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .rd       (rd),
        .clr      (clr),
        .addr_x   (ax),
        .addr_y   (ay),
        .data_in  (din),
        .data_out (a_do),
        .rd_valid (a_rv),
        .busy     (a_busy),
        .err      (a_err)
    );

    grid_memory #(
        .DATA_W (4),
        .WIDTH  (10),
        .HEIGHT (6),
        .ADDR_W (4),
        .ADDR_H (4)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .rd       (rd),
        .clr      (clr),
        .addr_x   (ax),
        .addr_y   (ay),
        .data_in  (din),
        .data_out (b_do),
        .rd_valid (b_rv),
        .busy     (b_busy),
        .err      (b_err)
    );

    always #5 clk = ~clk;

    // Model: cells as a plain array, the clear as a countdown of cells left.
    int         mw [2] = '{16, 10};
    int         mh [2] = '{16, 6};
    logic [3:0] mm [2][16][16];
    int         rem [2];
    logic [3:0] e_do [2];
    logic       e_rv [2];
    logic       e_err [2];

    always @(posedge clk or posedge rst) begin
        int  k;
        bit  ok;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rem[d]   = mw[d] * mh[d];
                e_do[d]  = 4'h0;
                e_rv[d]  = 1'b0;
                e_err[d] = 1'b0;
            end else if (rem[d] > 0) begin
                k = mw[d] * mh[d] - rem[d];
                mm[d][k / mh[d]][k % mh[d]] = 4'h0;
                rem[d]   = rem[d] - 1;
                e_rv[d]  = 1'b0;
                e_err[d] = 1'b0;
            end else if (clr) begin
                rem[d]   = mw[d] * mh[d];
                e_rv[d]  = 1'b0;
                e_err[d] = 1'b0;
            end else begin
                ok       = (int'(ax) < mw[d]) && (int'(ay) < mh[d]);
                e_err[d] = (rd || wr) && !ok;
                e_rv[d]  = rd && ok;
                if (rd && ok) e_do[d] = mm[d][ax][ay];
                if (wr && ok) mm[d][ax][ay] = din;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            total++;
            if ({a_do, a_rv, a_busy, a_err} !==
                {e_do[0], e_rv[0], rem[0] > 0, e_err[0]}) begin
                bad++;
                $display("FAIL cyc_a t=%0t got do=%h rv=%b busy=%b err=%b exp do=%h rv=%b busy=%b err=%b",
                         $time, a_do, a_rv, a_busy, a_err,
                         e_do[0], e_rv[0], rem[0] > 0, e_err[0]);
            end
            total++;
            if ({b_do, b_rv, b_busy, b_err} !==
                {e_do[1], e_rv[1], rem[1] > 0, e_err[1]}) begin
                bad++;
                $display("FAIL cyc_b t=%0t got do=%h rv=%b busy=%b err=%b exp do=%h rv=%b busy=%b err=%b",
                         $time, b_do, b_rv, b_busy, b_err,
                         e_do[1], e_rv[1], rem[1] > 0, e_err[1]);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // One clock edge; inputs change 1 unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic count_busy(output int n, output bit saw_rv);
        n      = 0;
        saw_rv = 1'b0;
        while (a_busy && n < 400) begin
            n++;
            step();
            saw_rv = saw_rv | a_rv;
        end
    endtask

    task automatic scan_a(output logic [3:0] acc, output int nrv);
        acc = 4'h0;
        nrv = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                rd = 1'b1;
                ax = 4'(x);
                ay = 4'(y);
                step();
                if (a_rv) begin
                    acc = acc | a_do;
                    nrv++;
                end
            end
        end
        rd = 1'b0;
        step();
    endtask

    initial begin
        int         n;
        bit         saw;
        logic [3:0] acc;
        int         nrv;

        #1;
        rst   = 1'b1;
        armed = 1'b1;
        repeat (3) step();
        chk("rst_state", {a_do, a_rv, a_busy, a_err}, 32'b0000_0_1_0);

        rst = 1'b0;
        count_busy(n, saw);
        chk("sweep_len", n, 256);
        chk("b_idle", b_busy, 0);

        wr  = 1'b1; ax = 4'd3; ay = 4'd7; din = 4'hA;
        step();
        chk("b_err_y_oor", b_err, 1);
        wr = 1'b0; rd = 1'b1;
        step();
        chk("rd_A", {a_rv, a_do}, {1'b1, 4'hA});
        rd = 1'b0;
        step();
        chk("hold_A", {a_rv, a_do}, {1'b0, 4'hA});

        wr = 1'b1; ax = 4'd2; ay = 4'd2; din = 4'h1;
        step();
        rd = 1'b1; din = 4'h0;
        step();
        chk("rf_old_a", {a_rv, a_do}, {1'b1, 4'h1});
        chk("rf_old_b", {b_rv, b_do}, {1'b1, 4'h1});
        wr = 1'b0;
        step();
        chk("rf_new_a", {a_rv, a_do}, {1'b1, 4'h0});

        ax = 4'd12; ay = 4'd0;
        step();
        chk("b_oor_rd", {b_rv, b_err}, {1'b0, 1'b1});
        chk("a_inr_rd", {a_rv, a_err}, {1'b1, 1'b0});
        rd = 1'b0; wr = 1'b1; din = 4'hF;
        step();
        chk("b_oor_wr", b_err, 1);
        wr = 1'b0;
        step();
        chk("err_pulse", b_err, 0);

        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; ax = 4'(i); ay = 4'(i % 6); din = 4'(i + 1);
            step();
        end
        wr = 1'b1; clr = 1'b1; ax = 4'd1; ay = 4'd1; din = 4'h9;
        step();
        wr = 1'b0; clr = 1'b0;
        chk("clr_busy", {a_busy, b_busy}, 2'b11);
        rd = 1'b1;
        count_busy(n, saw);
        chk("clr_len", n, 256);
        chk("clr_rd_dropped", saw, 0);
        rd = 1'b0;
        scan_a(acc, nrv);
        chk("clr_scan_zero", acc, 0);
        chk("clr_scan_cnt", nrv, 256);

        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (99) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {a_busy, a_rv, a_err}, 3'b100);
        step();
        rst = 1'b0;
        count_busy(n, saw);
        chk("restart_len", n, 256);
        scan_a(acc, nrv);
        chk("restart_scan", acc, 0);

        wr = 1'b1; ax = 4'd15; ay = 4'd15; din = 4'h5;
        step();
        wr = 1'b0; rd = 1'b1;
        step();
        chk("corner_rd", {a_rv, a_do}, {1'b1, 4'h5});
        rd = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_memory.md
GRID_MEMORY -- requirements
Module: grid_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 1: bits per cell.
REQ-002 SHALL have parameter WIDTH, default 16: number of columns (x), 2..256.
REQ-003 SHALL have parameter HEIGHT, default 16: number of rows (y), 2..256.
REQ-004 SHALL have parameter ADDR_W, default 4: x-address width, with 2**ADDR_W >= WIDTH.
REQ-005 SHALL have parameter ADDR_H, default 4: y-address width, with 2**ADDR_H >= HEIGHT.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port wr, input, 1: write request.
REQ-009 SHALL have port rd, input, 1: read request.
REQ-010 SHALL have port clr, input, 1: bulk-clear request.
REQ-011 SHALL have port addr_x, input, ADDR_W: column address.
REQ-012 SHALL have port addr_y, input, ADDR_H: row address.
REQ-013 SHALL have port data_in, input, DATA_W: write data.
REQ-014 SHALL have port data_out, output, DATA_W: registered read data.
REQ-015 SHALL have port rd_valid, output, 1: data_out is valid this cycle (single-cycle pulse).
REQ-016 SHALL have port busy, output, 1: clear sweep in progress.
REQ-017 SHALL have port err, output, 1: single-cycle pulse flagging a rejected out-of-range request.

Function
REQ-018 SHALL contain a WIDTH x HEIGHT array of DATA_W-bit cells, indexed [x][y].
REQ-019 SHALL write data_in to cell [addr_x][addr_y] at the clock edge when wr=1, busy=0 and the address is in range.
REQ-020 SHALL register the read: when rd=1, busy=0 and the address is in range, data_out and rd_valid=1 SHALL appear on the cycle after the request (latency 1).
REQ-021 SHALL hold data_out unchanged when no valid read occurs; rd_valid SHALL be 0 on those cycles.
REQ-022 SHALL return pre-write data for a simultaneous rd and wr to the same cell (read-first); the new value SHALL be visible to any later read.
REQ-023 SHALL treat addr_x >= WIDTH or addr_y >= HEIGHT as out of range when rd or wr is asserted: no write, rd_valid=0, and err=1 on the next cycle.
REQ-024 SHALL implement an FSM with states IDLE and CLEAR.
REQ-025 SHALL move IDLE->CLEAR on clr=1; in CLEAR it SHALL write zero to one cell per cycle, y incrementing fastest and x outer, starting at [0][0].
REQ-026 SHALL return CLEAR->IDLE after writing [WIDTH-1][HEIGHT-1], so a sweep lasts exactly WIDTH*HEIGHT cycles.
REQ-027 SHALL assert busy=1 throughout CLEAR and deassert it on the first IDLE cycle.
REQ-028 SHALL ignore rd, wr and clr while busy=1: no write, rd_valid=0, err=0.
REQ-029 SHALL give clr priority over rd and wr in the same IDLE cycle; the rd and wr are dropped.
REQ-030 SHALL wrap the sweep counters at WIDTH-1 and HEIGHT-1 (not at 2**ADDR), including for non-power-of-two dimensions.

Reset
REQ-031 SHALL, while rst=1, force data_out=0, rd_valid=0, err=0, the FSM to CLEAR with sweep counters at [0][0], and busy=1, all asynchronously.
REQ-032 SHALL begin the clear sweep on the first clock edge after rst deasserts, so the array is all-zero WIDTH*HEIGHT cycles after reset release.
REQ-033 SHALL restart the sweep from [0][0] if rst is asserted mid-sweep or mid-operation; any pending read SHALL be lost.

Structure
REQ-034 SHALL take the FSM state enum (IDLE, CLEAR) and the default-parameter constants from shared package grid_mem_pkg.
REQ-035 SHALL place the sweep counter and its terminal-count detection in one sub-module, grid_clear_ctrl, which outputs the current x/y, busy and done.
REQ-036 SHALL keep the array itself without reset; zeroing SHALL be achieved only by the sweep.

Verification
REQ-037 SHALL check reset-then-sweep: pulse rst, release it -> busy=1 for exactly 256 cycles (16x16), then every cell reads 0.
REQ-038 SHALL check write/read: with DATA_W=4, write 4'hA to [3][7], then read [3][7] -> data_out=4'hA with rd_valid=1 one cycle after the read request.
REQ-039 SHALL check read-first collision: with [2][2]=1, apply rd and wr of 0 to [2][2] in the same cycle -> data_out=1; the next read returns 0.
REQ-040 SHALL check range: with WIDTH=10, read at addr_x=12 -> err=1 next cycle, rd_valid=0; write at addr_x=12 -> no cell changes.
REQ-041 SHALL check clear: fill cells, pulse clr together with wr -> the wr is dropped, busy=1 for WIDTH*HEIGHT cycles, rd during busy gives rd_valid=0, all cells read 0 afterwards.
REQ-042 SHALL check mid-sweep reset: assert rst at cycle 100 of a sweep -> busy stays 1, and a full 256-cycle sweep runs again from [0][0].
